arm1_prog_loader: RTL and testbench

Program loader for the ARM1 core. It accepts a byte stream carrying one program image and checks it against a trailing checksum. It writes the image into the core's 16-word instruction/data memory, pads unused words with HLT, and only then releases the core from reset. It is the writing end of the memory that the processor executes and the testbench inspects after the run.

---
 rtl/arm1_prog_loader.sv | 129 ++++++++++++
 tb/tb_arm1_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm1_prog_loader.sv
// Program loader for the ARM1 core: receives a length-prefixed, checksummed byte
// stream, writes it into the 16-word memory, pads with HLT and then releases the core.
module arm1_prog_loader #(
   parameter int                ADDR_W   = 4,
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] HLT_WORD = 8'hF0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CHECK, PAD, RUN, ERR} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx;
   logic [ADDR_W-1:0] last_ptr, last_ptr_nx;
   logic [7:0]        sum, sum_nx;
   logic              we_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic              xfer;
   logic              bad_len;
   logic              full_image;

   assign in_ready   = (state == LEN) || (state == DATA) || (state == CHECK);
   assign xfer       = in_valid && in_ready;
   assign bad_len    = (in_data == 8'd0) || (int'(in_data) > DEPTH);
   assign full_image = (last_ptr == {ADDR_W{1'b1}});

   assign cpu_reset = (state != RUN);
   assign done      = (state == RUN);
   assign err       = (state == ERR);

   // State, pointers, checksum and the registered write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         last_ptr  <= '0;
         sum       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nx;
         wr_ptr    <= wr_ptr_nx;
         last_ptr  <= last_ptr_nx;
         sum       <= sum_nx;
         mem_we    <= we_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
      end
   end

   // The first pad word is issued on the checksum edge itself, so the pointer
   // wrapping to zero in PAD means address 15 has already been strobed and the
   // core is released one cycle after the final write.
   always_comb begin
      state_nx    = state;
      wr_ptr_nx   = wr_ptr;
      last_ptr_nx = last_ptr;
      sum_nx      = sum;
      we_nx       = 1'b0;
      addr_nx     = mem_addr;
      wdata_nx    = mem_wdata;
      case (state)
         IDLE, RUN, ERR: begin
            if (start) state_nx = LEN;
         end
         LEN: begin
            if (xfer) begin
               sum_nx      = in_data;
               wr_ptr_nx   = '0;
               last_ptr_nx = ADDR_W'(in_data - 8'd1);
               state_nx    = bad_len ? ERR : DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               we_nx     = 1'b1;
               addr_nx   = wr_ptr;
               wdata_nx  = DATA_W'(in_data);
               sum_nx    = sum + in_data;
               wr_ptr_nx = wr_ptr + ADDR_W'(1);
               if (wr_ptr == last_ptr) state_nx = CHECK;
            end
         end
         CHECK: begin
            if (xfer) begin
               if (in_data != sum) begin
                  state_nx = ERR;
               end else if (full_image) begin
                  state_nx = RUN;
               end else begin
                  state_nx  = PAD;
                  we_nx     = 1'b1;
                  addr_nx   = wr_ptr;
                  wdata_nx  = HLT_WORD;
                  wr_ptr_nx = wr_ptr + ADDR_W'(1);
               end
            end
         end
         PAD: begin
            if (wr_ptr == '0) begin
               state_nx = RUN;
            end else begin
               we_nx     = 1'b1;
               addr_nx   = wr_ptr;
               wdata_nx  = HLT_WORD;
               wr_ptr_nx = wr_ptr + ADDR_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_arm1_prog_loader.sv
// Self-checking bench for arm1_prog_loader: random and directed program images are
// compared against a stream-level model of the expected memory writes and outcome.
module tb_arm1_prog_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_reset;
   logic       done;
   logic       err;

   int passCount = 0;
   int checkCount = 0;

   logic [7:0]  stream[$];
   logic [11:0] writeQ[$];
   logic [11:0] expQ[$];
   logic [7:0]  shadowMem[16];
   bit          expDone;
   bit          expErr;
   bit          overlapSeen;

   arm1_prog_loader #(.ADDR_W(4), .DATA_W(8), .HLT_WORD(8'hF0)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_reset(cpu_reset), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Memory side: record every write strobe and catch the core being released mid-write
   always @(negedge clk) begin
      if (mem_we) begin
         writeQ.push_back({mem_addr, mem_wdata});
         shadowMem[mem_addr] = mem_wdata;
         if (!cpu_reset) overlapSeen = 1'b1;
      end
   end

   // Reference model: expected write list and outcome straight from the stream format
   task automatic buildModel();
      int n;
      logic [7:0] total;
      expQ.delete();
      n = int'(stream[0]);
      expDone = 1'b0;
      expErr  = 1'b1;
      if (n == 0 || n > 16) return;
      total = 8'h00;
      for (int i = 0; i <= n; i++) total = total + stream[i];
      for (int i = 0; i < n; i++) expQ.push_back({4'(i), stream[i+1]});
      if (stream[n+1] == total) begin
         for (int i = n; i < 16; i++) expQ.push_back({4'(i), 8'hF0});
         expDone = 1'b1;
         expErr  = 1'b0;
      end
   endtask

   task automatic makeStream(input int n, input bit corrupt);
      logic [7:0] total;
      logic [7:0] b;
      stream.delete();
      stream.push_back(8'(n));
      total = 8'(n);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         stream.push_back(b);
         total = total + b;
      end
      stream.push_back(corrupt ? (total ^ 8'h5A) : total);
   endtask

   // Drive the stream with optional random stalls and stray start pulses
   task automatic applyStimulus(input int stallPct, input bit startPulses, output bit ok);
      int i = 0;
      int guard = 0;
      while (i < stream.size() && guard < 400) begin
         @(negedge clk);
         guard++;
         start = startPulses && ($urandom_range(0, 3) == 0);
         if (int'($urandom_range(0, 99)) < stallPct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
         end else begin
            in_valid = 1'b1;
            in_data  = stream[i];
            if (in_ready) i++;
         end
      end
      ok = (i == stream.size());
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      reset = 1'b1;
      #1;
      checkCount++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err} !== 17'b0_0_0000_00000000_1_0_0) begin
         $display("[TB] FAIL reset_values: got %b expected %b",
                  {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err}, 17'b0_0_0000_00000000_1_0_0);
      end else passCount++;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkCount++;
      if ({in_ready, cpu_reset, done, err} !== 4'b0100)
         $display("[TB] FAIL idle_after_reset: got %b expected 0100", {in_ready, cpu_reset, done, err});
      else passCount++;
   endtask

   // One complete load of the current stream, checked against the model
   task automatic test_load(input string name, input int stallPct, input bit startPulses);
      bit ok;
      int n;
      logic [2:0] expEdge;
      bit bad;
      buildModel();
      n = int'(stream[0]);
      writeQ.delete();
      overlapSeen = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(stallPct, startPulses, ok);
      checkCount++;
      if (!ok) $display("[TB] FAIL %s_transfer_timeout: got stalled expected all bytes accepted", name);
      else passCount++;
      // Cycle right after the last byte: {done, err, mem_we}
      if (expErr)       expEdge = 3'b010;
      else if (n == 16) expEdge = 3'b100;
      else              expEdge = 3'b001;
      checkCount++;
      if ({done, err, mem_we} !== expEdge)
         $display("[TB] FAIL %s_after_last_byte: got %b expected %b (done,err,we)", name, {done, err, mem_we}, expEdge);
      else passCount++;
      for (int c = 0; c < 40 && !(done || err); c++) @(negedge clk);
      repeat (2) @(negedge clk);
      checkCount++;
      if ({done, err, cpu_reset} !== {expDone, expErr, !expDone})
         $display("[TB] FAIL %s_outcome: got %b expected %b (done,err,cpu_reset)",
                  name, {done, err, cpu_reset}, {expDone, expErr, !expDone});
      else passCount++;
      bad = (writeQ.size() != expQ.size());
      for (int i = 0; i < writeQ.size() && !bad; i++) bad = (writeQ[i] !== expQ[i]);
      checkCount++;
      if (bad) begin
         $display("[TB] FAIL %s_writes: got %0d writes expected %0d", name, writeQ.size(), expQ.size());
         for (int i = 0; i < writeQ.size() && i < expQ.size(); i++)
            if (writeQ[i] !== expQ[i]) $display("[TB]   write %0d got %h expected %h", i, writeQ[i], expQ[i]);
      end else passCount++;
      checkCount++;
      if (overlapSeen !== 1'b0)
         $display("[TB] FAIL %s_release_during_write: got 1 expected 0", name);
      else passCount++;
   endtask

   task automatic test_valid3();
      $display("[TB] test_valid3");
      stream = '{8'h03, 8'hCE, 8'hAF, 8'hF0, 8'h70};
      test_load("valid3", 0, 1'b0);
   endtask

   task automatic test_full16();
      $display("[TB] test_full16");
      makeStream(16, 1'b0);
      test_load("full16", 0, 1'b0);
   endtask

   task automatic test_bad_checksum();
      $display("[TB] test_bad_checksum");
      stream = '{8'h03, 8'hCE, 8'hAF, 8'hF0, 8'h71};
      test_load("bad_checksum", 0, 1'b0);
      makeStream(int'($urandom_range(1, 16)), 1'b0);
      test_load("recover", 0, 1'b0);
   endtask

   task automatic test_bad_header();
      $display("[TB] test_bad_header");
      stream = '{8'h00};
      test_load("header_00", 0, 1'b0);
      stream = '{8'h11};
      test_load("header_11", 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      $display("[TB] test_back_to_back");
      makeStream(5, 1'b0);
      test_load("stall5", 40, 1'b1);
      for (int k = 0; k < 6; k++) begin
         makeStream(int'($urandom_range(1, 16)), ($urandom_range(0, 3) == 0));
         test_load("random", 25, 1'b1);
      end
   endtask

   task automatic test_reset_midload();
      bit ok;
      logic [7:0] expWord;
      $display("[TB] test_reset_midload");
      stream = '{8'h10, 8'h12, 8'h34};
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      applyStimulus(0, 1'b0, ok);
      #2 reset = 1'b1;
      #1;
      checkCount++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err} !== 17'b0_0_0000_00000000_1_0_0)
         $display("[TB] FAIL midload_reset_values: got %b expected %b",
                  {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err}, 17'b0_0_0000_00000000_1_0_0);
      else passCount++;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkCount++;
      if ({in_ready, cpu_reset} !== 2'b01)
         $display("[TB] FAIL midload_idle: got %b expected 01 (in_ready,cpu_reset)", {in_ready, cpu_reset});
      else passCount++;
      makeStream(16, 1'b0);
      expWord = stream[15];
      test_load("reload", 10, 1'b0);
      checkCount++;
      if (shadowMem[14] !== expWord)
         $display("[TB] FAIL reload_mem14: got %h expected %h", shadowMem[14], expWord);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_valid3();
      test_full16();
      test_bad_checksum();
      test_bad_header();
      test_back_to_back();
      test_reset_midload();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
